// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter sharing a bank of NFLAG SR flag flops among NREQ requesters.
// Latency: grant is combinational in the accept cycle; sr code is registered (next cycle); shadow one cycle later.
// Backpressure: a requester holds req/op/idx until granted; no grant is issued while rst is high.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   req             request valid per requester
//   req_op          per requester: 1 = set flag, 0 = clear flag
//   req_idx         per requester flag index, requester i at [i*IDXW +: IDXW]
//   gnt             one-hot grant (combinational)
//   sr_bus          registered sr code per flag, flag k at [2k +: 2] (00 hold, 01 clear, 10 set)
//   flag_shadow     registered mirror of the flag bank
//   err_idx         registered one-cycle pulse when a granted index is out of range
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_op,
  input  logic [NREQ*IDXW-1:0]   req_idx,
  output logic [NREQ-1:0]        gnt,
  output logic [2*NFLAG-1:0]     sr_bus,
  output logic [NFLAG-1:0]       flag_shadow,
  output logic                   err_idx
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so NFLAG == 2**IDXW is representable for the range check.
  localparam logic [IDXW:0] NFLAG_L = (IDXW+1)'(NFLAG);

  logic [PTRW-1:0]    ptr;
  logic               found;
  logic [PTRW-1:0]    win;
  logic               win_op;
  logic [IDXW-1:0]    win_idx;
  logic               bad;
  logic [2*NFLAG-1:0] sr_nxt;

  // Issue register: the accepted in-range command whose shadow update lands
  // on the same edge at which the bank samples its sr code.
  logic               iss_vld;
  logic               iss_op;
  logic [IDXW-1:0]    iss_idx;

  // Round-robin scan starting at ptr, wrapping at NREQ-1 -> 0.
  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    found   = 1'b0;
    win     = '0;
    win_op  = 1'b0;
    win_idx = '0;
    if (!rst) begin
      for (int j = 0; j < NREQ; j++) begin
        c = int'(ptr) + j;
        if (c >= NREQ) c = c - NREQ;
        if (!found && req[c]) begin
          found   = 1'b1;
          win     = PTRW'(c);
          win_op  = req_op[c];
          win_idx = req_idx[c*IDXW +: IDXW];
          gnt[c]  = 1'b1;
        end
      end
    end
  end

  assign bad = found && ({1'b0, win_idx} >= NFLAG_L);

  // At most one field is ever driven, and only with 01 or 10.
  always_comb begin
    sr_nxt = '0;
    for (int k = 0; k < NFLAG; k++) begin
      if (found && !bad && (win_idx == IDXW'(k)))
        sr_nxt[2*k +: 2] = win_op ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      sr_bus      <= '0;
      flag_shadow <= '0;
      err_idx     <= 1'b0;
      iss_vld     <= 1'b0;
      iss_op      <= 1'b0;
      iss_idx     <= '0;
    end else begin
      if (found)
        ptr <= (win == PTRW'(NREQ-1)) ? '0 : win + PTRW'(1);
      sr_bus  <= sr_nxt;
      err_idx <= bad;
      iss_vld <= found && !bad;
      iss_op  <= win_op;
      iss_idx <= win_idx;
      for (int k = 0; k < NFLAG; k++) begin
        if (iss_vld && (iss_idx == IDXW'(k)))
          flag_shadow[k] <= iss_op;
      end
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  // Default-parameter instance (NFLAG=8)
  logic [3:0]  req, op;
  logic [11:0] idx;
  logic [3:0]  gnt;
  logic [15:0] sr_bus;
  logic [7:0]  shadow;
  logic        err;

  // Reduced bank instance (NFLAG=6) for out-of-range indices
  logic [3:0]  req6, op6;
  logic [11:0] idx6;
  logic [3:0]  gnt6;
  logic [11:0] sr6;
  logic [5:0]  sh6;
  logic        err6;

  int checks = 0;
  int errors = 0;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(op), .req_idx(idx),
    .gnt(gnt), .sr_bus(sr_bus), .flag_shadow(shadow), .err_idx(err)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .req_op(op6), .req_idx(idx6),
    .gnt(gnt6), .sr_bus(sr6), .flag_shadow(sh6), .err_idx(err6)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; op = '0; idx = '0; req6 = '0; op6 = '0; idx6 = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; op = '0; idx = '0; req6 = 4'b1111; op6 = '0; idx6 = '0;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || gnt6 !== 4'b0000) begin
        errors++; $display("FAIL reset_gnt cyc%0d: got %b/%b want 0000", i, gnt, gnt6);
      end
      checks++;
      if (sr_bus !== 16'h0 || shadow !== 8'h0 || err !== 1'b0) begin
        errors++; $display("FAIL reset_regs cyc%0d: sr=%h sh=%h err=%b want 0/0/0", i, sr_bus, shadow, err);
      end
      if (i == 0) step();
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt);
    end
    step();
    req = '0; req6 = '0;
  endtask

  task automatic test_single_set();
    do_reset();
    req = 4'b0001; op = 4'b0001; idx = 12'd5;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL set_gnt: got %b want 0001", gnt); end
    step();
    req = '0;
    @(negedge clk);
    checks++;
    if (sr_bus !== 16'h0800) begin errors++; $display("FAIL set_sr: got %h want 0800", sr_bus); end
    checks++;
    if (shadow !== 8'h00) begin errors++; $display("FAIL set_shadow_early: got %h want 00", shadow); end
    step();
    @(negedge clk);
    checks++;
    if (shadow !== 8'h20 || sr_bus !== 16'h0) begin
      errors++; $display("FAIL set_shadow: got sh=%h sr=%h want 20/0000", shadow, sr_bus);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 8; i++) begin
      exp = 4'b0001 << (i % 4);
      @(negedge clk);
      checks++;
      if (gnt !== exp) begin errors++; $display("FAIL rr_gnt cyc%0d: got %b want %b", i, gnt, exp); end
      step();
    end
    req = '0;
    step();
  endtask

  task automatic test_race();
    do_reset();
    req = 4'b0011; op = 4'b0001; idx = {3'd0, 3'd0, 3'd2, 3'd2};
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL race_gnt0: got %b want 0001", gnt); end
    step();
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL race_gnt1: got %b want 0010", gnt); end
    checks++;
    if (sr_bus !== 16'h0020) begin errors++; $display("FAIL race_sr_set: got %h want 0020", sr_bus); end
    step();
    req = '0;
    @(negedge clk);
    checks++;
    if (sr_bus !== 16'h0010 || shadow !== 8'h04) begin
      errors++; $display("FAIL race_sr_clr: got sr=%h sh=%h want 0010/04", sr_bus, shadow);
    end
    step();
    @(negedge clk);
    checks++;
    if (shadow !== 8'h00 || sr_bus !== 16'h0) begin
      errors++; $display("FAIL race_final: got sh=%h sr=%h want 00/0000", shadow, sr_bus);
    end
  endtask

  task automatic test_bad_index();
    do_reset();
    req6 = 4'b0001; op6 = 4'b0001; idx6 = 12'd1;
    @(negedge clk);
    checks++;
    if (gnt6 !== 4'b0001) begin errors++; $display("FAIL bad_pre_gnt: got %b want 0001", gnt6); end
    step();
    req6 = 4'b0100; op6 = 4'b0100; idx6 = {3'd0, 3'd7, 3'd0, 3'd0};
    @(negedge clk);
    checks++;
    if (gnt6 !== 4'b0100 || sr6 !== 12'h008) begin
      errors++; $display("FAIL bad_gnt: got gnt=%b sr=%h want 0100/008", gnt6, sr6);
    end
    step();
    req6 = '0;
    @(negedge clk);
    checks++;
    if (err6 !== 1'b1 || sr6 !== 12'h000 || sh6 !== 6'h02) begin
      errors++; $display("FAIL bad_err: got err=%b sr=%h sh=%h want 1/000/02", err6, sr6, sh6);
    end
    step();
    req6 = 4'b1111; op6 = '0; idx6 = '0;
    @(negedge clk);
    checks++;
    if (err6 !== 1'b0 || sr6 !== 12'h000 || sh6 !== 6'h02) begin
      errors++; $display("FAIL bad_after: got err=%b sr=%h sh=%h want 0/000/02", err6, sr6, sh6);
    end
    checks++;
    if (gnt6 !== 4'b1000) begin errors++; $display("FAIL bad_ptr: got %b want 1000", gnt6); end
    step();
    req6 = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001; op = 4'b0001; idx = 12'd3;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b want 0001", gnt); end
    step();
    req = '0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sr_bus !== 16'h0080 || shadow !== 8'h00) begin
      errors++; $display("FAIL mid_sr: got sr=%h sh=%h want 0080/00", sr_bus, shadow);
    end
    step();
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || sr_bus !== 16'h0 || shadow !== 8'h00) begin
      errors++; $display("FAIL mid_rst: got gnt=%b sr=%h sh=%h want 0000/0000/00", gnt, sr_bus, shadow);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || sr_bus !== 16'h0 || shadow !== 8'h00) begin
      errors++; $display("FAIL mid_after: got gnt=%b sr=%h sh=%h want 0001/0000/00", gnt, sr_bus, shadow);
    end
    step();
    req = '0;
    step();
  endtask

  task automatic test_stress();
    int nz;
    logic bad_code;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req = 4'($urandom); op = 4'($urandom); idx = 12'($urandom);
      req6 = 4'($urandom); op6 = 4'($urandom); idx6 = 12'($urandom);
      @(negedge clk);
      nz = 0; bad_code = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (sr_bus[2*k +: 2] != 2'b00) nz++;
        if (sr_bus[2*k +: 2] == 2'b11) bad_code = 1'b1;
      end
      checks++;
      if (bad_code || nz > 1) begin
        errors++; $display("FAIL stress_sr cyc%0d: got %h want no 11 and <=1 active field", i, sr_bus);
      end
      nz = 0; bad_code = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (sr6[2*k +: 2] != 2'b00) nz++;
        if (sr6[2*k +: 2] == 2'b11) bad_code = 1'b1;
      end
      checks++;
      if (bad_code || nz > 1) begin
        errors++; $display("FAIL stress_sr6 cyc%0d: got %h want no 11 and <=1 active field", i, sr6);
      end
      checks++;
      if ($countones(gnt) != (req != 0 ? 1 : 0) || (gnt & ~req) != 4'b0) begin
        errors++; $display("FAIL stress_gnt cyc%0d: got gnt=%b req=%b want one-hot subset", i, gnt, req);
      end
      step();
    end
    req = '0; req6 = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_race();
    test_bad_index();
    test_reset_mid();
    test_stress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
